fft_bfly_pipe: RTL
==================

Name: fft_bfly_pipe

Overview:
- Parametrised, pipelined radix-2 DIT butterfly for the FFT datapath. Computes c = a + b·W^k and d = a − b·W^k.
- Twiddle W^k = cos(2πk/N) − j·sin(2πk/N) comes from an internal ROM indexed by tw_idx.
- Successor to the fixed 32-bit, fixed-twiddle butterflies. Adds per-beat selectable 1/2 scaling, rounding, saturation with a sticky overflow flag, and valid/ready backpressure, so that any FFT stage is a single instance.

Parameters:
- DATA_W, 16: width of every real/imag data input and output (two's complement).
- COEF_W, 16: twiddle coefficient width; format Q2.(COEF_W−2), FRAC = COEF_W−2, so +1.0 = 2^FRAC.
- N_FFT, 8: FFT size (power of two, ≥4). The ROM holds N_FFT/2 entries.
- IDX_W, log2(N_FFT/2): tw_idx width (derived).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_en  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- tw_idx  in  IDX_W  twiddle index k, 0..N_FFT/2−1
- scale  in  1  1 = divide both results by 2 (travels with the beat)
- a_re, a_im, b_re, b_im  in  DATA_W each  signed operands
- out_ready  in  1  downstream accepts output
- out_en  out  1  output beat valid
- c_re, c_im, d_re, d_im  out  DATA_W each  signed results
- ovf  out  1  sticky saturation flag
- ovf_clr  in  1  synchronous clear of ovf

Behaviour:
- Reset (asynchronous, active-high): all pipeline valid bits, out_en, ovf and all data outputs go to 0 immediately. Reset mid-operation drops every in-flight beat; nothing emerges after release.
- ROM is built at elaboration. cos and sin are each rounded to nearest: round(2^FRAC·cos(2πk/N_FFT)) and round(2^FRAC·sin(2πk/N_FFT)). Example: k=0 gives (2^FRAC, 0).
- Pipeline has 3 register stages.
  - S1 registers the operands and scale, and performs the ROM lookup.
  - S2 forms the full-width products: pr = b_re·cos + b_im·sin, pi = b_im·cos − b_re·sin. Width is DATA_W+COEF_W+1.
  - S3 rounds each product: p = (p + 2^(FRAC−1)) >>> FRAC. It then forms c = a + p and d = a − p in DATA_W+2 bits. If scale=1, each result becomes (x + 1) >>> 1. Each result then saturates to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- Latency is 3 cycles from an accepted beat (in_en && in_ready) to out_en, with no stalls.
- Throughput is 1 beat/clk.
- Handshake:
  - stall = out_en && !out_ready; in_ready = !stall.
  - While stalled, every stage holds and the outputs stay stable. Bubbles are not collapsed.
  - An output beat completes when out_en && out_ready.
  - in_en while in_ready=0 is ignored; upstream must hold the beat.
- ovf:
  - Set in the cycle after any S3 result saturates, including while stalled on a held beat (set only once).
  - ovf_clr clears it. If clear and a new saturation occur in the same cycle, set wins.
- Out-of-range tw_idx cannot occur, because IDX_W exactly spans the ROM.
- Data outputs hold their last value when out_en=0.

Test Plan (DATA_W=16, COEF_W=16, N_FFT=8, out_ready=1 unless stated):
1. Unscaled, k=0: tw_idx=0, a=(1000,−200), b=(300,50), scale=0 → 3 cycles later out_en=1, c=(1300,−150), d=(700,−250), ovf=0.
2. Scaled: same as 1 with scale=1 → c=(650,−75), d=(350,−125).
3. Rotation, k=2 (W=−j): tw_idx=2, same a, b, scale=0 → b·W=(50,−300), so c=(1050,−500), d=(950,100).
4. Saturation: tw_idx=0, a=(32767,0), b=(32767,0), scale=0 → c=(32767,0) saturated, d=(0,0), ovf=1 and it stays 1. Pulse ovf_clr → ovf=0. Repeat with scale=1 → c_re=32767, no saturation, ovf stays 0.
5. Backpressure: stream 5 back-to-back beats, drop out_ready for 2 cycles mid-stream → in_ready low exactly those cycles, outputs stable while stalled, all 5 results delivered in order with no duplicates.
6. Reset mid-stream: 2 beats in flight, pulse rst asynchronously between clock edges → out_en, outputs and ovf go to 0 immediately. No output appears after rst deasserts until new beats are issued, and the first new beat has 3-cycle latency.

Source files
------------

// File: rtl/fft_bfly_pipe.sv
// Pipelined radix-2 DIT butterfly: c = a + b*W^k, d = a - b*W^k, with optional 1/2 scaling,
// rounding, saturation, a sticky overflow flag and valid/ready backpressure.
module fft_bfly_pipe #(
    parameter  int DATA_W = 16,
    parameter  int COEF_W = 16,
    parameter  int N_FFT  = 8,
    localparam int IDX_W  = $clog2(N_FFT / 2)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_en,
    output logic                     in_ready,
    input  logic        [IDX_W-1:0]  tw_idx,
    input  logic                     scale,
    input  logic signed [DATA_W-1:0] a_re,
    input  logic signed [DATA_W-1:0] a_im,
    input  logic signed [DATA_W-1:0] b_re,
    input  logic signed [DATA_W-1:0] b_im,
    input  logic                     out_ready,
    output logic                     out_en,
    output logic signed [DATA_W-1:0] c_re,
    output logic signed [DATA_W-1:0] c_im,
    output logic signed [DATA_W-1:0] d_re,
    output logic signed [DATA_W-1:0] d_im,
    output logic                     ovf,
    input  logic                     ovf_clr
);

    localparam int FRAC = COEF_W - 2;
    localparam int PW   = DATA_W + COEF_W + 1;
    localparam int SW   = DATA_W + 2;

    localparam logic signed [PW-1:0] RND     = PW'(longint'(1) << (FRAC - 1));
    localparam logic signed [SW:0]   ONE     = (SW + 1)'(1);
    localparam logic signed [SW:0]   SAT_MAX = (SW + 1)'((longint'(1) << (DATA_W - 1)) - 1);
    localparam logic signed [SW:0]   SAT_MIN = (SW + 1)'(-(longint'(1) << (DATA_W - 1)));

    // Elaboration-time twiddle: Taylor series of cos/sin, rounded to nearest in Q2.FRAC.
    function automatic logic signed [COEF_W-1:0] tw_coef(input int k, input logic want_sin);
        real x, term, acc_c, acc_s, val;
        int  r;
        x     = 2.0 * 3.14159265358979323846 * real'(k) / real'(N_FFT);
        term  = 1.0;
        acc_c = 0.0;
        acc_s = 0.0;
        for (int n = 0; n < 40; n++) begin
            case (n % 4)
                0:       acc_c = acc_c + term;
                1:       acc_s = acc_s + term;
                2:       acc_c = acc_c - term;
                default: acc_s = acc_s - term;
            endcase
            term = term * x / real'(n + 1);
        end
        val = (want_sin ? acc_s : acc_c) * real'(longint'(1) << FRAC);
        r   = (val >= 0.0) ? $rtoi(val + 0.5) : -$rtoi(0.5 - val);
        return COEF_W'(r);
    endfunction

    // Optional (x+1)>>>1, then clamp; MSB of the result flags saturation.
    function automatic logic [DATA_W:0] scale_sat(input logic signed [SW-1:0] x, input logic sc);
        logic signed [SW:0] y;
        y = (SW + 1)'(x);
        if (sc) begin
            y = (y + ONE) >>> 1;
        end
        if (y > SAT_MAX) begin
            return {1'b1, DATA_W'(SAT_MAX)};
        end else if (y < SAT_MIN) begin
            return {1'b1, DATA_W'(SAT_MIN)};
        end
        return {1'b0, DATA_W'(y)};
    endfunction

    logic signed [COEF_W-1:0] rom_cos [N_FFT/2];
    logic signed [COEF_W-1:0] rom_sin [N_FFT/2];

    for (genvar k = 0; k < N_FFT / 2; k++) begin : g_rom
        assign rom_cos[k] = tw_coef(k, 1'b0);
        assign rom_sin[k] = tw_coef(k, 1'b1);
    end

    logic                     v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic                     sc1_q, sc1_d, sc2_q, sc2_d;
    logic signed [DATA_W-1:0] a_re1_q, a_re1_d, a_im1_q, a_im1_d;
    logic signed [DATA_W-1:0] b_re1_q, b_re1_d, b_im1_q, b_im1_d;
    logic signed [COEF_W-1:0] cos1_q, cos1_d, sin1_q, sin1_d;
    logic signed [DATA_W-1:0] a_re2_q, a_re2_d, a_im2_q, a_im2_d;
    logic signed [PW-1:0]     pr2_q, pr2_d, pi2_q, pi2_d;
    logic signed [DATA_W-1:0] c_re_q, c_re_d, c_im_q, c_im_d;
    logic signed [DATA_W-1:0] d_re_q, d_re_d, d_im_q, d_im_d;
    logic                     ovf_q, ovf_d;

    logic                     stall;
    logic signed [SW-1:0]     p_re, p_im;
    logic        [DATA_W:0]   r_c_re, r_c_im, r_d_re, r_d_im;
    logic                     sat_any;

    assign stall    = v3_q && !out_ready;
    assign in_ready = !stall;
    assign out_en   = v3_q;
    assign c_re     = c_re_q;
    assign c_im     = c_im_q;
    assign d_re     = d_re_q;
    assign d_im     = d_im_q;
    assign ovf      = ovf_q;

    always_comb begin
        p_re    = SW'((pr2_q + RND) >>> FRAC);
        p_im    = SW'((pi2_q + RND) >>> FRAC);
        r_c_re  = scale_sat(SW'(a_re2_q) + p_re, sc2_q);
        r_c_im  = scale_sat(SW'(a_im2_q) + p_im, sc2_q);
        r_d_re  = scale_sat(SW'(a_re2_q) - p_re, sc2_q);
        r_d_im  = scale_sat(SW'(a_im2_q) - p_im, sc2_q);
        sat_any = r_c_re[DATA_W] | r_c_im[DATA_W] | r_d_re[DATA_W] | r_d_im[DATA_W];
    end

    // Every stage advances together unless the output is stalled; bubbles move with the beats.
    always_comb begin
        v1_d    = v1_q;
        sc1_d   = sc1_q;
        a_re1_d = a_re1_q;
        a_im1_d = a_im1_q;
        b_re1_d = b_re1_q;
        b_im1_d = b_im1_q;
        cos1_d  = cos1_q;
        sin1_d  = sin1_q;
        v2_d    = v2_q;
        sc2_d   = sc2_q;
        a_re2_d = a_re2_q;
        a_im2_d = a_im2_q;
        pr2_d   = pr2_q;
        pi2_d   = pi2_q;
        v3_d    = v3_q;
        c_re_d  = c_re_q;
        c_im_d  = c_im_q;
        d_re_d  = d_re_q;
        d_im_d  = d_im_q;
        ovf_d   = ovf_clr ? 1'b0 : ovf_q;
        if (!stall) begin
            v1_d = in_en;
            if (in_en) begin
                sc1_d   = scale;
                a_re1_d = a_re;
                a_im1_d = a_im;
                b_re1_d = b_re;
                b_im1_d = b_im;
                cos1_d  = rom_cos[tw_idx];
                sin1_d  = rom_sin[tw_idx];
            end
            v2_d = v1_q;
            if (v1_q) begin
                sc2_d   = sc1_q;
                a_re2_d = a_re1_q;
                a_im2_d = a_im1_q;
                pr2_d   = PW'(b_re1_q) * PW'(cos1_q) + PW'(b_im1_q) * PW'(sin1_q);
                pi2_d   = PW'(b_im1_q) * PW'(cos1_q) - PW'(b_re1_q) * PW'(sin1_q);
            end
            v3_d = v2_q;
            if (v2_q) begin
                c_re_d = r_c_re[DATA_W-1:0];
                c_im_d = r_c_im[DATA_W-1:0];
                d_re_d = r_d_re[DATA_W-1:0];
                d_im_d = r_d_im[DATA_W-1:0];
                if (sat_any) begin
                    ovf_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            sc1_q   <= 1'b0;
            a_re1_q <= '0;
            a_im1_q <= '0;
            b_re1_q <= '0;
            b_im1_q <= '0;
            cos1_q  <= '0;
            sin1_q  <= '0;
            v2_q    <= 1'b0;
            sc2_q   <= 1'b0;
            a_re2_q <= '0;
            a_im2_q <= '0;
            pr2_q   <= '0;
            pi2_q   <= '0;
            v3_q    <= 1'b0;
            c_re_q  <= '0;
            c_im_q  <= '0;
            d_re_q  <= '0;
            d_im_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            sc1_q   <= sc1_d;
            a_re1_q <= a_re1_d;
            a_im1_q <= a_im1_d;
            b_re1_q <= b_re1_d;
            b_im1_q <= b_im1_d;
            cos1_q  <= cos1_d;
            sin1_q  <= sin1_d;
            v2_q    <= v2_d;
            sc2_q   <= sc2_d;
            a_re2_q <= a_re2_d;
            a_im2_q <= a_im2_d;
            pr2_q   <= pr2_d;
            pi2_q   <= pi2_d;
            v3_q    <= v3_d;
            c_re_q  <= c_re_d;
            c_im_q  <= c_im_d;
            d_re_q  <= d_re_d;
            d_im_q  <= d_im_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule
